// File: rtl/sequence_generator_if.sv
// sequence_generator_if: start request, captured pattern/repeat inputs and serial output bundle
interface sequence_generator_if #(parameter int W = 4);
    logic         start;
    logic [W-1:0] pattern;
    logic [3:0]   reps;
    logic         out;
    logic         out_valid;
    logic         busy;
    logic         done;
    modport master (output start, pattern, reps, input out, out_valid, busy, done);
    modport slave  (input start, pattern, reps, output out, out_valid, busy, done);
endinterface

// File: rtl/sequence_generator.sv
// sequence_generator: repeats a captured W-bit pattern MSB-first with idle gaps, then pulses done
module sequence_generator #(
    parameter int   W        = 4,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input logic               clk,
    input logic               rst,
    sequence_generator_if.slave bus
);
    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] LAST = BW'(W - 1);
    localparam logic [3:0] GLAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    typedef enum logic [1:0] {IDLE, SEND, GAPW, DONE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [3:0]    rep_q, rep_d, repc_q, repc_d, gap_q, gap_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          out_q, valid_q, busy_q, done_q;
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        repc_d  = repc_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SEND;
                pat_d   = bus.pattern;
                rep_d   = bus.reps;
                repc_d  = '0;
                gap_d   = '0;
                bit_d   = '0;
            end
            SEND: begin
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST) begin
                    bit_d = '0;
                    if (repc_q == rep_q) state_d = DONE;
                    else begin
                        repc_d  = repc_q + 4'd1;
                        state_d = (GAP == 0) ? SEND : GAPW;
                    end
                end
            end
            GAPW: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == GLAST) begin
                    gap_d   = '0;
                    bit_d   = '0;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs are registered from the current state, so they trail it by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            repc_q  <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            out_q   <= IDLE_LVL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            repc_q  <= repc_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            out_q   <= (state_q == SEND) ? pat_q[LAST - bit_q] : IDLE_LVL;
            valid_q <= state_q == SEND;
            busy_q  <= state_q != IDLE;
            done_q  <= state_q == DONE;
        end
    end
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed per-cycle scenarios on three gap variants, bit k of each vector is cycle k
module tb_sequence_generator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern = '0;
    logic [3:0] reps = '0;
    int         sel = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] o;
    always #5 clk = ~clk;
    sequence_generator_if #(.W(4)) b0 ();
    sequence_generator_if #(.W(4)) b1 ();
    sequence_generator_if #(.W(4)) b2 ();
    assign b0.start = start;
    assign b0.pattern = pattern;
    assign b0.reps = reps;
    assign b1.start = start;
    assign b1.pattern = pattern;
    assign b1.reps = reps;
    assign b2.start = start;
    assign b2.pattern = pattern;
    assign b2.reps = reps;
    sequence_generator #(.W(4), .GAP(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    sequence_generator #(.W(4), .GAP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    sequence_generator #(.W(4), .GAP(2), .IDLE_LVL(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2));
    always_comb
        o = (sel == 0) ? {b0.out, b0.out_valid, b0.busy, b0.done} :
            (sel == 1) ? {b1.out, b1.out_valid, b1.busy, b1.done} :
                         {b2.out, b2.out_valid, b2.busy, b2.done};
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    task automatic scen(input string tag, input int s, input logic [3:0] pa, input logic [3:0] pb_pat,
                        input logic [3:0] r, input logic [31:0] st, input logic [31:0] rs,
                        input logic [31:0] pb, input logic [31:0] eo, input logic [31:0] ev,
                        input logic [31:0] eb, input logic [31:0] ed);
        logic [31:0] ro, rv, rb, rd;
        ro = '0;
        rv = '0;
        rb = '0;
        rd = '0;
        sel = s;
        reps = r;
        for (int k = 0; k < 20; k++) begin
            start = st[k];
            rst = rs[k];
            pattern = pb[k] ? pb_pat : pa;
            @(negedge clk);
            {ro[k], rv[k], rb[k], rd[k]} = o;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst = 1'b0;
        check({tag, ".out"}, ro, eo);
        check({tag, ".out_valid"}, rv, ev);
        check({tag, ".busy"}, rb, eb);
        check({tag, ".done"}, rd, ed);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset.gap0", {28'd0, b0.out, b0.out_valid, b0.busy, b0.done}, 32'h0);
        check("reset.gap1", {28'd0, b1.out, b1.out_valid, b1.busy, b1.done}, 32'h0);
        check("reset.gap2", {28'd0, b2.out, b2.out_valid, b2.busy, b2.done}, 32'h8);
        @(posedge clk);
        #1;
        scen("single", 1, 4'b0101, 4'b0101, 4'd0, 32'h1, 32'h0, 32'h0,
             32'h28, 32'h3C, 32'h7C, 32'h40);
        scen("gap2_rep1", 2, 4'b0101, 4'b0101, 4'd1, 32'h1, 32'h0, 32'h0,
             32'hFFAEB, 32'hF3C, 32'h1FFC, 32'h1000);
        scen("gap0_rep2", 0, 4'b1100, 4'b1100, 4'd2, 32'h1, 32'h0, 32'h0,
             32'hCCC, 32'h3FFC, 32'h7FFC, 32'h4000);
        scen("hold_start", 1, 4'b0101, 4'b1111, 4'd0, 32'h7F, 32'h0, 32'hFFFFFFF8,
             32'hF28, 32'hF3C, 32'h1F7C, 32'h1040);
        scen("mid_reset", 1, 4'b0101, 4'b0101, 4'd0, 32'h81, 32'h10, 32'h0,
             32'h1408, 32'h1E1C, 32'h3E1C, 32'h2000);
        scen("rst_vs_start", 1, 4'b0101, 4'b0101, 4'd0, 32'h1, 32'h1, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter: on a start request it captures a W-bit pattern and a repeat count, then emits the pattern MSB-first on a 1-bit line, one bit per clock. It repeats the pattern the requested number of times, inserting a configurable idle gap between repetitions, and signals completion with a one-cycle done pulse. It is the stimulus source for the team's serial sequence detectors. It is a three-block Moore FSM with registered outputs.

## Interface
- `W`, default 4: pattern width in bits, legal range 2..16.
- `GAP`, default 1: idle cycles between repetitions, legal range 0..15. A value of 0 means back-to-back repetitions.
- `IDLE_LVL`, default 1'b0: level driven on `out` whenever no bit is being sent.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: start request; sampled only while the FSM is in IDLE.
- `pattern`, input, W: bits to send; captured when `start` is accepted.
- `reps`, input, 4: extra repetitions; captured when `start` is accepted. The pattern is sent reps+1 times (1..16).
- `out`, output, 1: serial data.
- `out_valid`, output, 1: high while `out` carries a pattern bit.
- `busy`, output, 1: high from the first transmitted bit through the done cycle.
- `done`, output, 1: one-cycle pulse after the final bit.

## Operation
- State register block, next-state combinational block, registered output block. Outputs decode the current state, so they lag the state by one cycle.
- Internal registers:
  - `pat_reg` (W bits)
  - `rep_reg` and `rep_cnt` (4 bits each)
  - `bit_cnt` (clog2(W) bits)
  - `gap_cnt` (4 bits)
- States:
  - **IDLE**:
    - Outputs: out=IDLE_LVL, out_valid=0, busy=0, done=0.
    - Transition: `start`=1 → SEND. On that edge: capture `pattern`→`pat_reg` and `reps`→`rep_reg`, and clear `bit_cnt`, `rep_cnt`, `gap_cnt`.
  - **SEND**:
    - Outputs: out=pat_reg[W-1-bit_cnt], out_valid=1, busy=1.
    - `bit_cnt` increments each cycle.
    - When bit_cnt==W-1:
      - if rep_cnt==rep_reg → DONE;
      - else if GAP==0 → SEND, with bit_cnt=0 and rep_cnt+1;
      - else → GAPW, with rep_cnt+1.
  - **GAPW**:
    - Outputs: out=IDLE_LVL, out_valid=0, busy=1.
    - `gap_cnt` counts 0..GAP-1, then → SEND with bit_cnt=0 and gap_cnt=0.
  - **DONE**:
    - Outputs: done=1, busy=1, out=IDLE_LVL, out_valid=0.
    - Lasts one state cycle, then → IDLE unconditionally.
  - Unused encodings → IDLE.
- `start` is ignored in every state other than IDLE, including the cycle right after acceptance while `busy` is still low.
- Changes on `pattern` and `reps` after capture have no effect on the transmission in progress.

## Timing
- Reset: on any rising edge with rst=1, the FSM goes to IDLE and all counters clear. From the next cycle: out=IDLE_LVL, out_valid=0, busy=0, done=0.
  - `rst` has priority over `start`.
  - Reset mid-transmission aborts immediately, with no done pulse.
- `start` sampled high at the end of cycle c (FSM in IDLE):
  - state=SEND in cycle c+1;
  - the first (MSB) bit appears on `out` with out_valid=1 in cycle c+2.
- With W bits, R=reps+1 repetitions and gap G:
  - `out_valid` covers R windows of W cycles, separated by G idle cycles.
  - `done` occurs in cycle c+2+R·W+(R−1)·G.
  - `busy` spans cycle c+2 through the done cycle inclusive.
- Earliest next accepted `start`: the cycle in which `done` is high. The FSM is already in IDLE in that cycle, so back-to-back jobs are possible.

## Test plan
- W=4, GAP=1, pattern=4'b0101, reps=0, start pulsed in cycle 0:
  - out=0,1,0,1 with out_valid=1 in cycles 2–5;
  - done=1 in cycle 6 only;
  - busy=1 in cycles 2–6.
- Same pattern, reps=1, GAP=2:
  - out_valid=1 in cycles 2–5 and 8–11;
  - out=IDLE_LVL with out_valid=0 in cycles 6–7;
  - done in cycle 12.
- GAP=0, pattern=4'b1100, reps=2:
  - out=1,1,0,0,1,1,0,0,1,1,0,0 continuously in cycles 2–13;
  - done in cycle 14.
- `pattern` changed to 4'b1111 in cycle 3 of the first scenario:
  - transmitted bits remain 0,1,0,1.
  - `start` held high through cycles 0–5 produces exactly one job.
  - Re-asserting `start` in cycle 6 starts a second job, with its first bit in cycle 8.
- rst asserted in cycle 4 of the first scenario:
  - from cycle 5: out=IDLE_LVL, out_valid=0, busy=0;
  - no done pulse ever appears;
  - a `start` in cycle 7 yields its first bit in cycle 9.
- rst and start both high in the same cycle:
  - reset wins: outputs stay idle and no transmission begins.
